// File: rtl/servo_pkg.sv
// servo_pkg: state/sel encodings and microsecond-divider helper shared by the servo burst controller
package servo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_e;
  localparam logic [1:0] SEL_W0 = 2'd0, SEL_W1 = 2'd1, SEL_W2 = 2'd2, SEL_OFF = 2'd3;
  function automatic int us_div(input int clk_hz);
    return clk_hz / 1000000;
  endfunction
endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one servo output; start (frame boundary while running) loads the pulse length from sel, pwm stays high for W(sel) us
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int US_DIV    = 50,
  parameter int PERIOD_US = 20000,
  parameter int W0_US     = 1000,
  parameter int W1_US     = 1500,
  parameter int W2_US     = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] sel,
  output logic       pwm
);
  localparam int CW = $clog2(PERIOD_US * US_DIV);
  logic [CW-1:0] cnt, len;
  always_comb len = sel == SEL_W0 ? CW'(W0_US * US_DIV - 1) :
                    sel == SEL_W1 ? CW'(W1_US * US_DIV - 1) : CW'(W2_US * US_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pwm <= 1'b0;
      cnt <= '0;
    end else if (start && sel != SEL_OFF) begin
      pwm <= 1'b1;
      cnt <= len;
    end else if (cnt != '0) cnt <= cnt - 1'b1;
    else pwm <= 1'b0;
endmodule

// File: rtl/servo_burst_ctrl.sv
// servo_burst_ctrl: N_CH servo PWM with run/stop burst sequencer; in: clk rst_n enable sel on_steps off_steps, out: pwm frame_start state busy
module servo_burst_ctrl
  import servo_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int N_CH            = 2,
  parameter int PERIOD_US       = 20000,
  parameter int W0_US           = 1000,
  parameter int W1_US           = 1500,
  parameter int W2_US           = 2000,
  parameter int FRAMES_PER_STEP = 50,
  parameter int CNT_W           = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [2*N_CH-1:0]   sel,
  input  logic [CNT_W-1:0]    on_steps,
  input  logic [CNT_W-1:0]    off_steps,
  output logic [N_CH-1:0]     pwm,
  output logic                frame_start,
  output logic [1:0]          state,
  output logic                busy
);
  localparam int US_DIV = us_div(CLK_HZ);
  localparam int PW     = US_DIV > 1 ? $clog2(US_DIV) : 1;
  localparam int FW     = $clog2(PERIOD_US);
  localparam int SW     = $clog2(FRAMES_PER_STEP * (2 ** CNT_W));
  localparam int SW1    = SW + 1;
  if (US_DIV < 1 || CLK_HZ % 1000000 != 0) begin : g_bad_clk
    $error("CLK_HZ must be a nonzero multiple of 1 MHz");
  end
  if (W0_US >= PERIOD_US || W1_US >= PERIOD_US || W2_US >= PERIOD_US) begin : g_bad_w
    $error("pulse widths must be shorter than the frame");
  end
  logic [PW-1:0]    pre;
  logic [FW-1:0]    fcnt;
  logic             us_tick, wrap, relatch, done;
  logic [SW-1:0]    scnt;
  logic [CNT_W-1:0] on_l, off_l, len;
  logic [SW:0]      tgt;
  state_e           st, nxt;
  assign us_tick = pre == PW'(US_DIV - 1);
  assign wrap    = us_tick && fcnt == FW'(PERIOD_US - 1);
  assign state   = st;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre         <= '0;
      fcnt        <= '0;
      frame_start <= 1'b0;
    end else begin
      pre         <= us_tick ? '0 : pre + 1'b1;
      fcnt        <= wrap ? '0 : us_tick ? fcnt + 1'b1 : fcnt;
      frame_start <= wrap;
    end
  // a zero-length OFF phase is treated as one step so both-zero counts get re-evaluated every step
  always_comb len  = st == ON ? on_l : off_l == '0 ? CNT_W'(1) : off_l;
  assign tgt  = SW1'(len) * SW1'(FRAMES_PER_STEP);
  assign done = ({1'b0, scnt} + 1'b1) == tgt;
  always_comb begin
    nxt     = st;
    relatch = 1'b0;
    if (!enable) nxt = IDLE;
    else if (st == IDLE) relatch = 1'b1;
    else if (done) begin
      if (st == ON && off_l != '0) nxt = OFF;
      else relatch = 1'b1;
    end
    if (relatch) nxt = on_steps != '0 ? ON : OFF;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      busy  <= 1'b0;
      scnt  <= '0;
      on_l  <= '0;
      off_l <= '0;
    end else if (frame_start) begin
      st   <= nxt;
      busy <= nxt != IDLE;
      scnt <= (nxt == IDLE || nxt != st || done) ? '0 : scnt + 1'b1;
      if (relatch) begin
        on_l  <= on_steps;
        off_l <= off_steps;
      end
    end
  // channels start on the same boundary the FSM enters or stays in ON
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    servo_pwm_channel #(
      .US_DIV(US_DIV), .PERIOD_US(PERIOD_US), .W0_US(W0_US), .W1_US(W1_US), .W2_US(W2_US)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .start(frame_start && nxt == ON),
      .sel  (sel[2*i+:2]),
      .pwm  (pwm[i])
    );
  end
endmodule

// File: tb/tb_servo_burst_ctrl.sv
// tb_servo_burst_ctrl: frame-level self-check of servo_burst_ctrl against a phase-countdown reference model
module tb_servo_burst_ctrl;
  localparam int D = 2, FPS = 2, FRAME = 200;
  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [3:0] sel = '0, on_steps = '0, off_steps = '0;
  logic [1:0] pwm, state;
  logic       frame_start, busy;
  int vecs = 0, errs = 0;
  int ms = 0, left = 0, moff = 0;
  int exp_w[2];
  servo_burst_ctrl #(
    .CLK_HZ(2000000), .N_CH(2), .PERIOD_US(100), .W0_US(10), .W1_US(15), .W2_US(20),
    .FRAMES_PER_STEP(FPS), .CNT_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sel(sel), .on_steps(on_steps),
    .off_steps(off_steps), .pwm(pwm), .frame_start(frame_start), .state(state), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int width_clks(input logic [1:0] s);
    return s == 2'd3 ? 0 : (10 + 5 * int'(s)) * D;
  endfunction
  // phase model: state plus frames remaining in the current phase, updated once per frame boundary
  task automatic model_step();
    bit relatch;
    relatch = 1'b0;
    if (!enable) ms = 0;
    else if (ms == 0) relatch = 1'b1;
    else begin
      left = left - 1;
      if (left == 0) begin
        if (ms == 1 && moff != 0) begin
          ms = 2;
          left = moff * FPS;
        end else relatch = 1'b1;
      end
    end
    if (relatch) begin
      moff = int'(off_steps);
      ms   = on_steps != 0 ? 1 : 2;
      left = (on_steps != 0 ? int'(on_steps) : off_steps != 0 ? int'(off_steps) : 1) * FPS;
    end
    for (int i = 0; i < 2; i++) exp_w[i] = ms == 1 ? width_clks(sel[2*i+:2]) : 0;
  endtask
  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2 * FRAME);
  endtask
  // entered at the negedge where frame_start is high; returns at the next one
  task automatic frame(input string tag, input bit chg, input logic n_en, input logic [3:0] n_sel,
                       input logic [3:0] n_on, input logic [3:0] n_off);
    int hi0, hi1, fs;
    hi0 = 0; hi1 = 0; fs = 0;
    model_step();
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk({tag, ".state"}, state, ms);
        chk({tag, ".busy"}, busy, ms != 0);
      end
      if (k == 50 && chg) begin
        enable = n_en; sel = n_sel; on_steps = n_on; off_steps = n_off;
      end
      if (k < FRAME) begin
        fs  += int'(frame_start);
        hi0 += int'(pwm[0]);
        hi1 += int'(pwm[1]);
      end
    end
    chk({tag, ".pwm0"}, hi0, exp_w[0]);
    chk({tag, ".pwm1"}, hi1, exp_w[1]);
    chk({tag, ".fs_mid"}, fs, 0);
    chk({tag, ".fs_edge"}, frame_start, 1);
  endtask
  task automatic hold(input string tag);
    frame(tag, 1'b0, enable, sel, on_steps, off_steps);
  endtask
  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst.pwm", pwm, 0);
    chk("rst.state", state, 0);
    chk("rst.busy", busy, 0);
    chk("rst.fs", frame_start, 0);
    rst_n = 1'b1;
    wait_fs(n);
    chk("first_fs", n, FRAME);
    frame("idle", 1'b1, 1'b1, 4'b1000, 4'd3, 4'd0);
    repeat (8) hold("run");
    frame("run_to_burst", 1'b1, 1'b1, 4'b1000, 4'd2, 4'd1);
    repeat (12) hold("burst");
    frame("burst_to_cont", 1'b1, 1'b1, 4'b1000, 4'd3, 4'd0);
    repeat (6) hold("cont");
    frame("selchg", 1'b1, 1'b1, 4'b1001, 4'd3, 4'd0);
    hold("selchg_next");
    frame("en_drop", 1'b1, 1'b0, 4'b1001, 4'd3, 4'd0);
    frame("dropped", 1'b1, 1'b1, 4'b1001, 4'd0, 4'd0);
    repeat (5) hold("zero");
    repeat (30)
      frame("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0, 4'($urandom),
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
    frame("pre_idle", 1'b1, 1'b0, 4'b1000, 4'd1, 4'd0);
    frame("pre_run", 1'b1, 1'b1, 4'b1000, 4'd1, 4'd0);
    repeat (10) @(negedge clk);
    chk("rstmid.pulse", pwm[1], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.pwm", pwm, 0);
    chk("rstmid.state", state, 0);
    chk("rstmid.busy", busy, 0);
    ms = 0; left = 0; moff = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_fs(n);
    chk("rst2_fs", n, FRAME);
    repeat (2) hold("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/servo_burst_ctrl.md
Name: servo_burst_ctrl

Overview:
Multi-channel hobby-servo PWM generator with a built-in run/stop burst sequencer. It runs the servos for a programmable number of steps, then holds them idle for a programmable number of steps, and repeats. This emulates an average speed on continuous-rotation servos. It sits between the board clock and the servo/LED pins and replaces ad-hoc divider-plus-selector test tops.

Parameters:
CLK_HZ, 50000000, input clock frequency; CLK_HZ/1000000 = US_DIV must be an integer ≥1
N_CH, 2, number of servo channels
PERIOD_US, 20000, PWM frame length in µs
W0_US, 1000, pulse width for sel=0
W1_US, 1500, pulse width for sel=1
W2_US, 2000, pulse width for sel=2
FRAMES_PER_STEP, 50, frames per sequencer step (50 frames = 1 s at default)
CNT_W, 4, width of on/off step counts

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request, level
sel  in  2*N_CH  per-channel width select; ch i uses sel[2i+1:2i]; 3 = constant low
on_steps  in  CNT_W  steps in ON phase
off_steps  in  CNT_W  steps in OFF phase
pwm  out  N_CH  servo pulse outputs, registered
frame_start  out  1  one-cycle pulse at each frame boundary
state  out  2  0 IDLE, 1 ON, 2 OFF
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs and counters are cleared. pwm=0, frame_start=0, state=IDLE, busy=0. This holds mid-pulse; the output drops immediately.
- µs prescaler: counts 0..US_DIV-1. It produces us_tick on the terminal count.
- Frame counter: counts us_tick 0..PERIOD_US-1 and free-runs from reset regardless of state.
  - frame_start is asserted for 1 clk when the frame counter wraps to 0.
  - The first frame_start occurs PERIOD_US*US_DIV clks after reset release.
- Every state transition and every sel/on_steps/off_steps sample happens only in the frame_start cycle. Nothing changes mid-frame, so there is no glitching.
- FSM (evaluated in the frame_start cycle):
  - IDLE: if enable, latch on_steps and off_steps.
    - If on_steps≠0, go to ON.
    - Else if off_steps≠0, go to OFF.
    - Else go to OFF and hold there.
  - ON: the frame counter-of-step counts frames. When on_steps*FRAMES_PER_STEP frames are complete:
    - If off_steps_latched≠0, go to OFF.
    - Else re-latch and stay in ON (continuous run).
  - OFF: when off_steps*FRAMES_PER_STEP frames are complete, re-latch both counts.
    - If on≠0, go to ON; else stay in OFF.
  - Both counts zero: OFF, pwm stays low, re-evaluated each step.
  - enable=0 sampled in any state: go to IDLE at that frame_start. The step counter is cleared.
- Pulse generation, per channel:
  - At frame_start in state ON (including the cycle of entering ON), latch sel_i.
  - pwm[i] goes high the clk after frame_start and stays high for exactly W(sel_i)*US_DIV clks.
  - sel_i=3, IDLE, or OFF gives pwm[i]=0 for the whole frame.
  - A pulse already in progress always completes, even if the FSM leaves ON at the next boundary. Boundaries coincide with pulse start, so this only matters under reset.
- Step counter width is $clog2(FRAMES_PER_STEP*(2**CNT_W)). The products fit without overflow.
- Elaboration checks: W0_US, W1_US and W2_US must each be < PERIOD_US. US_DIV must be ≥1.

Decomposition:
- Package servo_pkg:
  - state enum (IDLE/ON/OFF)
  - sel encodings (SEL_W0, SEL_W1, SEL_W2, SEL_OFF=3)
  - function us_div(CLK_HZ)
- Sub-module servo_pwm_channel: latches sel at frame_start when run=1 and produces a pulse width counter. Instantiate it N_CH times via generate.
- Timebase (prescaler + frame counter) and FSM stay in the top.

Test Plan:
Bench parameters: CLK_HZ=2000000, PERIOD_US=100, W0/W1/W2=10/15/20, FRAMES_PER_STEP=2, N_CH=2.
- Reset/idle: rst_n low, then high with enable=0. Expect pwm=0, state=0, and frame_start every 200 clks with the first at clk 200.
- Basic run: enable=1, sel={2'd2,2'd0}, on=3, off=0.
  - At the next frame_start, state becomes 1.
  - pwm[0] is high for 20 clks per frame; pwm[1] is high for 40 clks per frame.
  - The system stays in ON indefinitely.
- Burst: on=2, off=1.
  - Expect 4 frames with pulses, then 2 frames with pwm=0 and state=2, repeating.
  - busy stays 1 throughout.
- sel changed mid-frame (0→1 at clk 50 of a frame): the current pulse stays 20 clks. The next frame's pulse is 30 clks.
- Corner counts:
  - on=0, off=0 with enable=1: state=2, pwm=0 forever.
  - enable dropped mid-ON: pulses continue until the next frame_start, then state=0.
- Async reset mid-pulse: rst_n low at clk 10 of a 40-clk pulse. pwm goes low the same cycle (no clk edge needed) and state=0.
